// File: rtl/divisor_frecuencia.sv
// Baud-rate clock generator: divides clk_in by a rounded integer ratio and drives a
// near-50 % duty clk_div straight from a flip-flop (low phase first, then high).
module divisor_frecuencia #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_div
);

    // Guarded divisor keeps elaboration from dividing by zero before the check below fires.
    localparam int unsigned BAUD_NZ = (BAUD == 0) ? 1 : BAUD;
    localparam int unsigned DIV     = (CLK_HZ + BAUD_NZ / 2) / BAUD_NZ;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned LOW     = DIV - HALF;
    localparam int unsigned CW      = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(LOW);

    if (BAUD == 0) begin : g_err_baud_zero
        $error("divisor_frecuencia: BAUD must be non-zero");
    end
    if (BAUD > CLK_HZ) begin : g_err_baud_high
        $error("divisor_frecuencia: BAUD must not exceed CLK_HZ");
    end
    if (DIV < 2) begin : g_err_div_small
        $error("divisor_frecuencia: division ratio must be at least 2");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    always_comb begin
        cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    // Output is decided from the next count so clk_div stays a bare register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            clk_div <= (cnt_n >= CNT_RISE);
        end
    end

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Self-checking bench: four divider configurations sharing one clock and reset, compared each
// cycle against an edge-count model, with directed and randomized reset episodes.
module tb_divisor_frecuencia;

    logic clk;
    logic reset;
    logic div_def, div_10, div_7, div_11;

    int tests;
    int fails;
    int k;  // rising edges seen since the last reset release

    divisor_frecuencia u_def (
        .clk_in (clk),
        .reset  (reset),
        .clk_div(div_def)
    );

    divisor_frecuencia #(.CLK_HZ(100), .BAUD(10)) u_d10 (
        .clk_in (clk),
        .reset  (reset),
        .clk_div(div_10)
    );

    divisor_frecuencia #(.CLK_HZ(70), .BAUD(10)) u_d7 (
        .clk_in (clk),
        .reset  (reset),
        .clk_div(div_7)
    );

    divisor_frecuencia #(.CLK_HZ(105), .BAUD(10)) u_d11 (
        .clk_in (clk),
        .reset  (reset),
        .clk_div(div_11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: edge k of a period of div cycles is high once its phase reaches the low time.
    function automatic logic model(input int edges, input int div, input int low);
        if (edges == 0) return 1'b0;
        return ((edges % div) >= low) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        check("def", div_def, model(k, 5208, 2604));
        check("d10", div_10, model(k, 10, 5));
        check("d7", div_7, model(k, 7, 4));
        check("d11", div_11, model(k, 11, 6));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (reset) k++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Assert reset half a cycle after an edge, confirm the asynchronous drop, hold, release.
    task automatic reset_pulse(input int hold);
        reset = 1'b0;
        #1;
        check("async_def", div_def, 1'b0);
        check("async_d10", div_10, 1'b0);
        check("async_d7", div_7, 1'b0);
        check("async_d11", div_11, 1'b0);
        k = 0;
        run_cycles(hold);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        k     = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Defaults: four full periods plus margin covers rise at 2604, fall at 5208.
        run_cycles(4 * 5208 + 20);

        // Mid-high reset for the DIV=10 instance: edge 7 is in its high phase.
        @(negedge clk);
        reset_pulse(2);
        run_cycles(7);
        check("d10_high_at_7", div_10, 1'b1);
        reset_pulse(3);
        run_cycles(4);
        check("d10_low_at_4", div_10, 1'b0);
        run_cycles(1);
        check("d10_rise_at_5", div_10, 1'b1);
        run_cycles(200);

        // Randomized run lengths and reset hold times.
        for (int r = 0; r < 6; r++) begin
            run_cycles(int'($urandom_range(1, 4000)));
            reset_pulse(int'($urandom_range(1, 5)));
            run_cycles(int'($urandom_range(1, 60)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
